// File: rtl/expr_recognizer.sv
// Streaming recognizer for ASCII arithmetic expressions with multi-digit operands and nested parentheses.
// Build option: define SPACE_SKIP_EN to ignore spaces; a space ends a number.
module expr_recognizer #(
  parameter int MAX_DEPTH  = 4,
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 8
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic [7:0]                       in,
  input  logic                             in_vld,
  output logic                             out,
  output logic                             err,
  output logic [$clog2(MAX_DEPTH+1)-1:0]   depth,
  output logic [CNT_W-1:0]                 op_cnt
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int NW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] S_OPND  = 2'd0;
  localparam logic [1:0] S_NUM   = 2'd1;
  localparam logic [1:0] S_CLOSE = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]       state, nstate;
  logic [NW-1:0]    dcnt, ndcnt;
  logic [DW-1:0]    ndepth;
  logic [CNT_W-1:0] nop;

  logic is_dig, is_op, is_lp, is_rp, sp_skip;

  assign is_dig = (in >= 8'h30) && (in <= 8'h39);
  assign is_op  = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
  assign is_lp  = (in == 8'h28);
  assign is_rp  = (in == 8'h29);

`ifdef SPACE_SKIP_EN
  assign sp_skip = (in == 8'h20);
`else
  assign sp_skip = 1'b0;
`endif

  always_comb begin
    nstate = state;
    ndcnt  = dcnt;
    ndepth = depth;
    nop    = op_cnt;
    // A skipped space only matters inside a number, where it closes the operand.
    if (sp_skip) begin
      if (state == S_NUM) nstate = S_CLOSE;
    end else begin
      case (state)
        S_OPND: begin
          if (is_dig) begin
            nstate = S_NUM;
            ndcnt  = NW'(1);
          end else if (is_lp) begin
            if (depth == DW'(MAX_DEPTH)) nstate = S_ERR;
            else ndepth = depth + DW'(1);
          end else begin
            nstate = S_ERR;
          end
        end
        S_NUM, S_CLOSE: begin
          if (is_dig && state == S_NUM) begin
            if (dcnt == NW'(MAX_DIGITS)) nstate = S_ERR;
            else ndcnt = dcnt + NW'(1);
          end else if (is_op) begin
            nstate = S_OPND;
            if (!(&op_cnt)) nop = op_cnt + CNT_W'(1);
          end else if (is_rp) begin
            if (depth == '0) begin
              nstate = S_ERR;
            end else begin
              nstate = S_CLOSE;
              ndepth = depth - DW'(1);
            end
          end else begin
            nstate = S_ERR;
          end
        end
        default: nstate = S_ERR;
      endcase
    end
  end

  // Error transitions leave depth and op_cnt at their pre-error values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_OPND;
      dcnt   <= '0;
      depth  <= '0;
      op_cnt <= '0;
    end else if (in_vld) begin
      state <= nstate;
      if (nstate != S_ERR) begin
        dcnt   <= ndcnt;
        depth  <= ndepth;
        op_cnt <= nop;
      end
    end
  end

  assign out = ((state == S_NUM) || (state == S_CLOSE)) && (depth == '0);
  assign err = (state == S_ERR);

endmodule

// File: tb/tb_expr_recognizer.sv
// Scoreboard bench for expr_recognizer: a token-level reference model predicts every edge.
module tb_expr_recognizer;

  localparam int MAX_DEPTH  = 4;
  localparam int MAX_DIGITS = 4;
  localparam int CNT_W      = 8;
  localparam int DW         = $clog2(MAX_DEPTH + 1);
`ifdef SPACE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic             out;
    logic             err;
    logic [DW-1:0]    depth;
    logic [CNT_W-1:0] ops;
  } exp_t;

  logic             clk;
  logic             clr;
  logic [7:0]       in;
  logic             in_vld;
  logic             out;
  logic             err;
  logic [DW-1:0]    depth;
  logic [CNT_W-1:0] op_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  byte  hist[$];

  expr_recognizer #(.MAX_DEPTH(MAX_DEPTH), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .in(in), .in_vld(in_vld),
    .out(out), .err(err), .depth(depth), .op_cnt(op_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: scan the accepted string as tokens, stopping at the first offending character.
  function automatic exp_t evaluate(input byte h[$]);
    exp_t e;
    int   open = 0;
    int   ops = 0;
    int   run = 0;
    bit   bad = 0;
    bit   want_operand = 1;
    bit   in_number = 0;
    for (int i = 0; i < h.size(); i++) begin
      byte c = h[i];
      if (bad) break;
      if (c >= "0" && c <= "9") begin
        if (want_operand) begin
          want_operand = 0; in_number = 1; run = 1;
        end else if (in_number && run < MAX_DIGITS) run++;
        else bad = 1;
      end else if (c == "+" || c == "-" || c == "*" || c == "/") begin
        if (want_operand) bad = 1;
        else begin
          want_operand = 1; in_number = 0;
          if (ops < (1 << CNT_W) - 1) ops++;
        end
      end else if (c == "(") begin
        if (want_operand && open < MAX_DEPTH) open++;
        else bad = 1;
      end else if (c == ")") begin
        if (!want_operand && open > 0) begin
          open--; in_number = 0;
        end else bad = 1;
      end else if (c == " " && SKIP) begin
        in_number = 0;
      end else begin
        bad = 1;
      end
    end
    e.out   = !bad && !want_operand && (open == 0);
    e.err   = bad;
    e.depth = DW'(open);
    e.ops   = CNT_W'(ops);
    return e;
  endfunction

  task automatic applyStimulus(input bit c, input bit v, input byte ch);
    @(negedge clk);
    clr = c; in_vld = v; in = ch;
    @(posedge clk);
    #1;
    if (c) hist.delete();
    else if (v) hist.push_back(ch);
    expq.push_back(evaluate(hist));
  endtask

  task automatic feed(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(1'b0, 1'b1, s[i]);
      if (gaps) applyStimulus(1'b0, 1'b0, 8'h41);
    end
  endtask

  task automatic checkOutput(input string name, input bit eo, input bit ee,
                             input int ed, input int eop);
    checks++;
    if (out !== eo || err !== ee || depth !== DW'(ed) || op_cnt !== CNT_W'(eop)) begin
      errors++;
      $display("[TB] FAIL %s: got out=%0b err=%0b depth=%0d op_cnt=%0d, want out=%0b err=%0b depth=%0d op_cnt=%0d",
               name, out, err, depth, op_cnt, eo, ee, ed, eop);
    end
  endtask

  // Monitor: every edge that the driver issued has one prediction waiting in the queue.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if (out !== e.out || err !== e.err || depth !== e.depth || op_cnt !== e.ops) begin
        errors++;
        $display("[TB] FAIL scoreboard t=%0t: got out=%0b err=%0b depth=%0d op_cnt=%0d, want out=%0b err=%0b depth=%0d op_cnt=%0d",
                 $time, out, err, depth, op_cnt, e.out, e.err, e.depth, e.ops);
      end
    end
  end

  initial begin
    string pool;
    clr = 1'b0; in_vld = 1'b0; in = 8'h00;
    pool = "0123456789+-*/+(()))(x 7";

    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("reset", 0, 0, 0, 0);

    feed("1+2*3", 0);
    checkOutput("1+2*3", 1, 0, 0, 2);

    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("123*45", 0);
    checkOutput("123*45", 1, 0, 0, 1);
    feed("67890", 0);
    checkOutput("digit overflow", 0, 1, 0, 1);

    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("9999", 0);
    checkOutput("max digits", 1, 0, 0, 0);

    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("((7-2)*3)", 0);
    checkOutput("nested", 1, 0, 0, 2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("(((((", 0);
    checkOutput("depth overflow", 0, 1, 4, 0);

    applyStimulus(1'b1, 1'b0, 8'h00);
    feed(")", 0);
    checkOutput("leading rp", 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("1+", 0);
    checkOutput("1+", 0, 0, 0, 1);
    feed("+", 0);
    checkOutput("1++", 0, 1, 0, 1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("1a", 0);
    checkOutput("1a", 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("1)", 0);
    checkOutput("rp underflow", 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("-1", 0);
    checkOutput("unary minus", 0, 1, 0, 0);

    for (int g = 0; g < 2; g++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      feed("1+(2", g[0]);
      applyStimulus(1'b1, 1'b0, 8'h00);
      feed("9", g[0]);
      checkOutput(g ? "clr mid gaps" : "clr mid", 1, 0, 0, 0);
    end

    applyStimulus(1'b1, 1'b0, 8'h00);
`ifdef SPACE_SKIP_EN
    feed("1 + 2", 0);
    checkOutput("spaces", 1, 0, 0, 1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("12 3", 0);
    checkOutput("split number", 0, 1, 0, 0);
`else
    feed("1 ", 0);
    checkOutput("space illegal", 0, 1, 0, 0);
`endif

    applyStimulus(1'b1, 1'b0, 8'h00);
    feed("1", 0);
    for (int i = 0; i < 300; i++) feed("+1", 0);
    checkOutput("op_cnt saturate", 1, 0, 0, 255);

    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      int  r;
      byte ch;
      r  = $urandom_range(0, 99);
      ch = pool[$urandom_range(0, pool.len() - 1)];
      if (r < 2 || (err && r < 25)) applyStimulus(1'b1, $urandom_range(0, 1) == 1, ch);
      else if (r < 20) applyStimulus(1'b0, 1'b0, ch);
      else applyStimulus(1'b0, 1'b1, ch);
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d predictions left, want 0", expq.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
